// File: rtl/naval_pkg.sv
// Shared encodings and the default 5x7 ship layouts for the naval battle core.
package naval_pkg;

    typedef enum logic [1:0] {
        ST_SELECT = 2'b00,
        ST_PLAY   = 2'b01,
        ST_WON    = 2'b10,
        ST_LOST   = 2'b11
    } game_state_e;

    typedef enum logic [1:0] {
        DISP_SHIPS      = 2'b00,
        DISP_SHIPS_HITS = 2'b01,
        DISP_ATTACKS    = 2'b10,
        DISP_BLINK      = 2'b11
    } status_e;

    localparam int DEF_COLS    = 5;
    localparam int DEF_ROWS    = 7;
    localparam int MAX_LAYOUTS = 8;

    // Bit index = col*DEF_ROWS + row; each entry is {col4, col3, col2, col1, col0}, row 0 in the LSB.
    localparam logic [34:0] LAYOUT_TABLE [MAX_LAYOUTS] = '{
        {7'b1000000, 7'b0010000, 7'b0010000, 7'b0000000, 7'b0000111},
        {7'b0000001, 7'b1100000, 7'b0000000, 7'b0001111, 7'b0000000},
        {7'b0011100, 7'b0000000, 7'b1000000, 7'b1000000, 7'b1000000},
        {7'b0000001, 7'b0000001, 7'b0000111, 7'b0000000, 7'b0110000},
        {7'b0000110, 7'b0000000, 7'b0111000, 7'b0000000, 7'b0000011},
        {7'b1000000, 7'b0000011, 7'b0000000, 7'b0011100, 7'b0000000},
        {7'b0000000, 7'b0001110, 7'b0000000, 7'b0000000, 7'b1110000},
        {7'b0111100, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000000}
    };

    localparam logic [5:0] LAYOUT_COUNT [MAX_LAYOUTS] = '{
        6'd6, 6'd7, 6'd6, 6'd7, 6'd7, 6'd6, 6'd6, 6'd7
    };

endpackage

// File: rtl/naval_battle_core_layout_rom.sv
// Combinational layout lookup: layout index -> ship bitmap (col-major) and ship-cell count.
module layout_rom
    import naval_pkg::*;
#(
    parameter int COLS        = 5,
    parameter int ROWS        = 7,
    parameter int NUM_LAYOUTS = 4,
    localparam int LIDX_W     = $clog2(NUM_LAYOUTS)
) (
    input  logic [LIDX_W-1:0]    i_layout_idx,
    output logic [COLS*ROWS-1:0] o_ship_map,
    output logic [5:0]           o_ship_count
);

    // Board sizes other than 5x7 take the overlapping corner of the default table.
    for (genvar gi = 0; gi < COLS*ROWS; gi++) begin : g_cell
        localparam int C = gi / ROWS;
        localparam int R = gi % ROWS;
        if (C < DEF_COLS && R < DEF_ROWS) begin : g_in
            assign o_ship_map[gi] = LAYOUT_TABLE[i_layout_idx][C*DEF_ROWS + R];
        end else begin : g_out
            assign o_ship_map[gi] = 1'b0;
        end
    end

    if (COLS == DEF_COLS && ROWS == DEF_ROWS) begin : g_table_count
        assign o_ship_count = LAYOUT_COUNT[i_layout_idx];
    end else begin : g_pop_count
        always_comb begin
            o_ship_count = '0;
            for (int i = 0; i < COLS*ROWS; i++) begin
                o_ship_count = o_ship_count + 6'(o_ship_map[i]);
            end
        end
    end

endmodule

// File: rtl/naval_battle_core.sv
// Battleship game core: layout select, attack bookkeeping, win/loss FSM and a column-scanned LED matrix.
module naval_battle_core
    import naval_pkg::*;
#(
    parameter int COLS        = 5,
    parameter int ROWS        = 7,
    parameter int NUM_LAYOUTS = 4,
    parameter int MAX_ATTACKS = 10,
    parameter int SCAN_DIV    = 1,
    parameter int BLINK_DIV   = 190,
    localparam int CW         = $clog2(COLS),
    localparam int RW         = $clog2(ROWS)
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic [1:0]      i_status,
    input  logic [CW-1:0]   i_col_attack,
    input  logic [RW-1:0]   i_row_attack,
    input  logic            i_attack,
    input  logic            i_layout_next,
    input  logic            i_layout_confirm,
    input  logic            i_game_restart,
    output logic [COLS-1:0] o_columns,
    output logic [ROWS-1:0] o_lines,
    output logic [1:0]      o_game_state,
    output logic [5:0]      o_attempts_left,
    output logic [5:0]      o_hits,
    output logic            o_attack_hit,
    output logic            o_attack_miss,
    output logic            o_attack_reject
);

    localparam int LIDX_W = $clog2(NUM_LAYOUTS);
    localparam int CELL_W = $clog2(COLS*ROWS);
    localparam int SW     = $clog2(SCAN_DIV + 1);
    localparam int BW     = $clog2(BLINK_DIV + 1);

    game_state_e           r_state;
    logic [LIDX_W-1:0]     r_layout_idx;
    logic [COLS*ROWS-1:0]  r_ship_map;
    logic [COLS*ROWS-1:0]  r_atk_map;
    logic [5:0]            r_ship_count;
    logic [5:0]            r_attempts;
    logic [5:0]            r_hits;
    logic                  r_attack_hit;
    logic                  r_attack_miss;
    logic                  r_attack_reject;
    logic [SW-1:0]         r_div;
    logic [CW-1:0]         r_col_idx;
    logic [BW-1:0]         r_wraps;
    logic                  r_blink;
    logic [COLS-1:0]       r_columns;
    logic [ROWS-1:0]       r_lines;

    logic [COLS*ROWS-1:0]  w_rom_map;
    logic [5:0]            w_rom_count;
    logic                  w_in_range;
    logic [CELL_W-1:0]     w_cell;
    logic [COLS-1:0]       w_col_onehot;
    logic [ROWS-1:0]       w_lines;

    layout_rom #(
        .COLS        (COLS),
        .ROWS        (ROWS),
        .NUM_LAYOUTS (NUM_LAYOUTS)
    ) u_layout_rom (
        .i_layout_idx (r_layout_idx),
        .o_ship_map   (w_rom_map),
        .o_ship_count (w_rom_count)
    );

    assign w_in_range = (int'(i_col_attack) < COLS) && (int'(i_row_attack) < ROWS);
    assign w_cell     = w_in_range ? CELL_W'(int'(i_col_attack) * ROWS + int'(i_row_attack)) : '0;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state         <= ST_SELECT;
            r_layout_idx    <= '0;
            r_ship_map      <= '0;
            r_atk_map       <= '0;
            r_ship_count    <= '0;
            r_attempts      <= 6'(MAX_ATTACKS);
            r_hits          <= '0;
            r_attack_hit    <= 1'b0;
            r_attack_miss   <= 1'b0;
            r_attack_reject <= 1'b0;
        end else begin
            r_attack_hit    <= 1'b0;
            r_attack_miss   <= 1'b0;
            r_attack_reject <= 1'b0;
            if (i_game_restart) begin
                r_state    <= ST_SELECT;
                r_ship_map <= '0;
                r_atk_map  <= '0;
                r_attempts <= 6'(MAX_ATTACKS);
                r_hits     <= '0;
            end else begin
                case (r_state)
                    ST_SELECT: begin
                        if (i_layout_confirm) begin
                            r_ship_map   <= w_rom_map;
                            r_ship_count <= w_rom_count;
                            r_atk_map    <= '0;
                            r_attempts   <= 6'(MAX_ATTACKS);
                            r_hits       <= '0;
                            r_state      <= ST_PLAY;
                        end else if (i_layout_next) begin
                            r_layout_idx <= r_layout_idx + LIDX_W'(1);
                        end
                    end
                    ST_PLAY: begin
                        // Game end is judged on the counters as updated by the previous attack.
                        if (r_hits == r_ship_count) begin
                            r_state <= ST_WON;
                        end else if (r_attempts == '0) begin
                            r_state <= ST_LOST;
                        end else if (i_attack) begin
                            if (!w_in_range || r_atk_map[w_cell]) begin
                                r_attack_reject <= 1'b1;
                            end else begin
                                r_atk_map[w_cell] <= 1'b1;
                                r_attempts        <= r_attempts - 6'd1;
                                if (r_ship_map[w_cell]) begin
                                    r_attack_hit <= 1'b1;
                                    r_hits       <= r_hits + 6'd1;
                                end else begin
                                    r_attack_miss <= 1'b1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        assign w_col_onehot[gi] = (r_col_idx == CW'(gi));
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        logic [CELL_W-1:0] w_idx;
        logic              w_ship;
        logic              w_atk;
        logic              w_play_pix;
        assign w_idx  = CELL_W'(int'(r_col_idx) * ROWS + gi);
        assign w_ship = r_ship_map[w_idx];
        assign w_atk  = r_atk_map[w_idx];
        always_comb begin
            case (i_status)
                DISP_SHIPS:      w_play_pix = w_ship;
                DISP_SHIPS_HITS: w_play_pix = w_ship | w_atk;
                DISP_ATTACKS:    w_play_pix = w_atk;
                default:         w_play_pix = (w_atk & ~w_ship) | (w_atk & w_ship & r_blink);
            endcase
        end
        assign w_lines[gi] = (r_state == ST_SELECT) ? w_rom_map[w_idx] :
                             (r_state == ST_PLAY)   ? w_play_pix : 1'b1;
    end

    // Strobe and pixels are registered from the same column index, so they always agree.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_div     <= '0;
            r_col_idx <= '0;
            r_wraps   <= '0;
            r_blink   <= 1'b0;
            r_columns <= '0;
            r_lines   <= '0;
        end else begin
            r_columns <= w_col_onehot;
            r_lines   <= w_lines;
            if (r_div == SW'(SCAN_DIV - 1)) begin
                r_div <= '0;
                if (r_col_idx == CW'(COLS - 1)) begin
                    r_col_idx <= '0;
                    if (r_wraps == BW'(BLINK_DIV - 1)) begin
                        r_wraps <= '0;
                        r_blink <= ~r_blink;
                    end else begin
                        r_wraps <= r_wraps + BW'(1);
                    end
                end else begin
                    r_col_idx <= r_col_idx + CW'(1);
                end
            end else begin
                r_div <= r_div + SW'(1);
            end
        end
    end

    assign o_columns       = r_columns;
    assign o_lines         = r_lines;
    assign o_game_state    = r_state;
    assign o_attempts_left = r_attempts;
    assign o_hits          = r_hits;
    assign o_attack_hit    = r_attack_hit;
    assign o_attack_miss   = r_attack_miss;
    assign o_attack_reject = r_attack_reject;

endmodule

// File: tb/tb_naval_battle_core.sv
// Directed bench: attack results go through a pulse scoreboard; counters, state and display are checked inline.
module tb_naval_battle_core;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] status;
    logic [2:0] col;
    logic [2:0] row;
    logic       atk;
    logic       lnext;
    logic       lconf;
    logic       restart;
    logic [4:0] columns;
    logic [6:0] lines;
    logic [1:0] gstate;
    logic [5:0] attempts;
    logic [5:0] hits;
    logic       p_hit;
    logic       p_miss;
    logic       p_rej;

    always #5 clk = ~clk;

    naval_battle_core dut (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_status         (status),
        .i_col_attack     (col),
        .i_row_attack     (row),
        .i_attack         (atk),
        .i_layout_next    (lnext),
        .i_layout_confirm (lconf),
        .i_game_restart   (restart),
        .o_columns        (columns),
        .o_lines          (lines),
        .o_game_state     (gstate),
        .o_attempts_left  (attempts),
        .o_hits           (hits),
        .o_attack_hit     (p_hit),
        .o_attack_miss    (p_miss),
        .o_attack_reject  (p_rej)
    );

    localparam logic [2:0] K_HIT  = 3'b100;
    localparam logic [2:0] K_MISS = 3'b010;
    localparam logic [2:0] K_REJ  = 3'b001;
    localparam logic [2:0] K_NONE = 3'b000;

    typedef struct {
        logic [2:0] kind;
        int         at;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation, in kind and cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (p_hit || p_miss || p_rej)) begin
            if (q.size() == 0) begin
                check("unexpected pulse", {p_hit, p_miss, p_rej}, K_NONE);
            end else begin
                e = q.pop_front();
                check("pulse kind", {p_hit, p_miss, p_rej}, e.kind);
                check("pulse cycle", cyc, e.at);
                $display("pulse kind=%b at cycle %0d (hits=%0d attempts=%0d)", {p_hit, p_miss, p_rej}, cyc, hits, attempts);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_next();
        step();
        lnext = 1'b1;
        step();
        lnext = 1'b0;
    endtask

    task automatic pulse_confirm();
        step();
        lconf = 1'b1;
        step();
        lconf = 1'b0;
    endtask

    task automatic pulse_restart();
        step();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic fire(input int c, input int r, input logic [2:0] kind);
        step();
        col = 3'(c);
        row = 3'(r);
        atk = 1'b1;
        if (kind != K_NONE) q.push_back('{kind, cyc + 1});
        step();
        atk = 1'b0;
    endtask

    task automatic check_col(input string name, input int c, input logic [6:0] exp);
        int n;
        logic [4:0] strobe;
        strobe = 5'(1 << c);
        n = 0;
        repeat (2) step();
        while (columns !== strobe && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " strobe"}, columns, strobe);
        check(name, lines, exp);
        step();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1; status = 2'b00; col = '0; row = '0;
        atk = 1'b0; lnext = 1'b0; lconf = 1'b0; restart = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset columns", columns, 5'b0);
        check("reset lines", lines, 7'b0);
        check("reset state", gstate, 2'b00);
        check("reset attempts", attempts, 6'd10);
        check("reset hits", hits, 6'd0);
        check("reset pulses", {p_hit, p_miss, p_rej}, K_NONE);
        step();
        rst = 1'b0;
        step();
        check("first strobe", columns, 5'b00001);

        // Five advances wrap to layout 1; preview must show regardless of status.
        status = 2'b11;
        repeat (5) pulse_next();
        check("select state", gstate, 2'b00);
        check_col("preview L1 c0", 0, 7'b0000000);
        check_col("preview L1 c1", 1, 7'b0001111);
        check_col("preview L1 c2", 2, 7'b0000000);
        check_col("preview L1 c3", 3, 7'b1100000);
        check_col("preview L1 c4", 4, 7'b0000001);

        repeat (3) pulse_next();
        pulse_confirm();
        check("play state", gstate, 2'b01);
        check("play attempts", attempts, 6'd10);

        status = 2'b01;
        fire(0, 0, K_HIT);
        check("hit hits", hits, 6'd1);
        check("hit attempts", attempts, 6'd9);
        fire(0, 0, K_REJ);
        fire(5, 0, K_REJ);
        fire(0, 7, K_REJ);
        check("reject attempts", attempts, 6'd9);
        check("reject hits", hits, 6'd1);

        check_col("ships+hits c0", 0, 7'b0000111);
        status = 2'b10;
        check_col("attacks c0", 0, 7'b0000001);
        status = 2'b00;
        check_col("ships c2", 2, 7'b0010000);
        fire(1, 3, K_MISS);
        status = 2'b11;
        check_col("blink hit c0", 0, 7'b0000000);
        check_col("blink miss c1", 1, 7'b0001000);

        // Restart wins over a simultaneous attack; layout index is kept.
        step();
        restart = 1'b1; atk = 1'b1; col = 3'd1; row = 3'd0;
        step();
        restart = 1'b0; atk = 1'b0;
        check("restart state", gstate, 2'b00);
        status = 2'b10;
        check_col("restart preview L0 c0", 0, 7'b0000111);
        pulse_confirm();
        check("restart attempts", attempts, 6'd10);
        check("restart hits", hits, 6'd0);
        check_col("cleared attacks c0", 0, 7'b0000000);
        check_col("cleared attacks c1", 1, 7'b0000000);

        // Ten misses lose the game.
        for (int r = 0; r < 7; r++) fire(1, r, K_MISS);
        for (int r = 0; r < 3; r++) fire(2, r, K_MISS);
        check("lose attempts", attempts, 6'd0);
        step();
        check("lost state", gstate, 2'b11);
        fire(4, 6, K_NONE);
        check("lost state kept", gstate, 2'b11);
        check_col("lost all on", 3, 7'b1111111);

        // Final hit on the final attempt wins.
        pulse_restart();
        pulse_confirm();
        for (int r = 0; r < 4; r++) fire(1, r, K_MISS);
        fire(0, 0, K_HIT);
        fire(0, 1, K_HIT);
        fire(0, 2, K_HIT);
        fire(2, 4, K_HIT);
        fire(3, 4, K_HIT);
        fire(4, 6, K_HIT);
        check("win hits", hits, 6'd6);
        check("win attempts", attempts, 6'd0);
        step();
        check("won state", gstate, 2'b10);

        repeat (3) step();
        check("pending pulses", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
